// File: rtl/divider_pkg.sv
// Shared execute-stage definitions: operand width, Signal function codes and
// the control-state encoding used by the multiplier/divider FSMs.
package divider_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SIG_W = 6;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [SIG_W-1:0] DIVU = 6'b011011;
    localparam logic [SIG_W-1:0] MUL  = 6'b011000;
    localparam logic [SIG_W-1:0] OUT  = 6'b111111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, and keep the difference only when it did not borrow.
module divider_div_step
    import divider_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // 33-bit trial so divisors with the top bit set still compare correctly
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    // The kept remainder is always below the divisor, so it fits in WIDTH bits
    always_comb begin
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, result
// presented as {remainder, quotient} and held until the next completion.
module divider
    import divider_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [SIG_W-1:0]     Signal,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 busy,
    output logic                 done
);

    logic [1:0]           state, state_n;
    logic [CNT_W-1:0]     counter, counter_n;
    logic [WIDTH-1:0]     quo, quo_n;
    logic [WIDTH-1:0]     rem, rem_n;
    logic [WIDTH-1:0]     divisor, divisor_n;
    logic [2*WIDTH-1:0]   data_out_n;
    logic                 busy_n, done_n;
    logic [WIDTH-1:0]     rem_step, quo_step;

    divider_div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            dataOut <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
            quo     <= quo_n;
            rem     <= rem_n;
            divisor <= divisor_n;
            dataOut <= data_out_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        counter_n  = counter;
        quo_n      = quo;
        rem_n      = rem;
        divisor_n  = divisor;
        data_out_n = dataOut;
        busy_n     = busy;
        done_n     = done;

        case (state)
            IDLE, DONE: begin
                if (Signal == DIVU) begin
                    if (dataB != '0) begin
                        divisor_n = dataB;
                        quo_n     = dataA;
                        rem_n     = '0;
                        counter_n = '0;
                        state_n   = RUN;
                        busy_n    = 1'b1;
                        done_n    = 1'b0;
                    end else begin
                        data_out_n = {dataA, {WIDTH{1'b1}}};
                        state_n    = DONE;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                    end
                end else if (state == DONE && Signal == OUT) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                end
            end
            RUN: begin
                rem_n     = rem_step;
                quo_n     = quo_step;
                counter_n = counter + CNT_W'(1);
                if (counter == CNT_W'(WIDTH - 1)) begin
                    data_out_n = {rem_step, quo_step};
                    state_n    = DONE;
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases from the plan plus random
// operands checked against a plain-arithmetic division model.
module tb_divider;

    localparam logic [5:0] C_DIVU = 6'b011011;
    localparam logic [5:0] C_OUT  = 6'b111111;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    divider dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    // Start a divide, wait for done, check latency, busy count, held result
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit disturb, input bit ack);
        int          cycles;
        int          busy_cnt;
        bit          stable;
        logic [63:0] old_out;
        old_out  = dataOut;
        dataA    = a;
        dataB    = b;
        Signal   = C_DIVU;
        tick();
        Signal   = 6'd0;
        cycles   = 0;
        busy_cnt = 0;
        stable   = 1'b1;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (dataOut !== old_out) stable = 1'b0;
            if (disturb) begin
                dataA  = $urandom;
                dataB  = $urandom;
                Signal = (cycles % 3 == 1) ? C_DIVU : ((cycles % 3 == 2) ? C_OUT : 6'd0);
            end
            tick();
            cycles++;
        end
        Signal = 6'd0;
        check({tag, " latency"}, 64'(cycles), (b == 32'd0) ? 64'd0 : 64'd32);
        check({tag, " busy_cycles"}, 64'(busy_cnt), (b == 32'd0) ? 64'd0 : 64'd32);
        check({tag, " held_during_run"}, 64'(stable), 64'd1);
        check({tag, " result"}, dataOut, exp);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        if (ack) begin
            Signal = C_OUT;
            tick();
            Signal = 6'd0;
            check({tag, " done_after_ack"}, 64'(done), 64'd0);
            check({tag, " result_kept"}, dataOut, exp);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        dataA    = '0;
        dataB    = '0;
        Signal   = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset dataOut", dataOut, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);

        do_div("basic", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b1);
        do_div("max_by_one", 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0, 1'b1);
        do_div("top_bit_div", 32'h8000_0000, 32'h8000_0001, 64'h80000000_00000000, 1'b0, 1'b1);
        do_div("div_zero", 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b0, 1'b1);
        do_div("stability", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1, 1'b1);

        // Reset in the middle of an operation
        dataA  = 32'd12345;
        dataB  = 32'd77;
        Signal = C_DIVU;
        tick();
        Signal = 6'd0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst dataOut", dataOut, 64'd0);
        do_div("after_reset", 32'd1000, 32'd10, 64'h00000000_00000064, 1'b0, 1'b1);

        // OUT then DIVU, and DIVU issued straight from DONE
        do_div("b2b_acked", 32'd9, 32'd4, 64'h00000001_00000002, 1'b0, 1'b0);
        do_div("b2b_direct", 32'd9, 32'd4, 64'h00000001_00000002, 1'b0, 1'b0);
        do_div("b2b_from_done", 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'h8000_0000 | $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            do_div("random", ra, rb, model(ra, rb), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential unsigned 32-bit shift-subtract (restoring) divider; the inverse of the shift-add multiplier in the same datapath.
- Sits beside the multiplier in the execute stage and is driven by the same 6-bit Signal function code.
- Produces {remainder, quotient} on a 64-bit result bus in HI/LO layout for DIVU.
- One quotient bit per clock; 32 iterations per operation.

Parameters:
- WIDTH, 32, operand width; dataOut is 2*WIDTH.
- DIVU, 6'b011011, Signal code that starts an unsigned divide.
- OUT, 6'b111111, Signal code that acknowledges a completed result.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- dataA  input  32  dividend, sampled only on the start cycle.
- dataB  input  32  divisor, sampled only on the start cycle.
- Signal  input  6  function code (DIVU starts, OUT acknowledges, all others ignored).
- dataOut  output  64  result register: [63:32] remainder, [31:0] quotient.
- busy  output  1  high while iterating.
- done  output  1  high from completion until acknowledged.

Behaviour:
- Reset (sync, active-high, overrides everything incl. mid-operation):
  - state=IDLE, dataOut=0, busy=0, done=0.
  - counter, quotient, remainder and divisor registers cleared.
- States: IDLE, RUN, DONE.
- IDLE, Signal==DIVU, dataB!=0:
  - Latch divisor=dataB, quo=dataA, rem=0 (33-bit), counter=0.
  - Go to RUN; busy=1 from the next cycle.
- IDLE, Signal==DIVU, dataB==0:
  - Go straight to DONE.
  - dataOut={dataA, 32'hFFFFFFFF}; done=1 on the next cycle.
- RUN, each cycle:
  - Form s = {rem[31:0], quo[31]} (33 bits) and d = s - {1'b0, divisor}.
  - If d[32]==0: rem=d, quo={quo[30:0],1}. Otherwise: rem=s, quo={quo[30:0],0}.
  - counter increments.
- RUN, iteration with counter==31:
  - Load dataOut={rem_next[31:0], quo_next}.
  - Go to DONE; busy=0, done=1.
- Latency: DIVU accepted at edge k; result and done valid after edge k+32; busy high for exactly 32 cycles.
- RUN ignores Signal entirely: DIVU does not restart, OUT does not abort.
- DONE, Signal==OUT: done=0, go to IDLE. dataOut keeps its value until the next completion or reset.
- DONE, Signal==DIVU: accepted as a new start (same rules as IDLE). done=0 and busy=1 next cycle. dataOut holds the old result until the new one completes.
- dataOut changes only on completion or reset, never during RUN.
- Remainder must use the 33-bit path so divisors with bit31 set divide correctly.
- Quotient bit derives from the subtraction borrow only; no signed handling.

Decomposition:
- Shared package (common with multiplier/ALU): Signal encodings DIVU, MUL, OUT; WIDTH; state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Optional sub-module div_step: combinational single iteration, (rem, quo, divisor) -> (rem_next, quo_next). Keeps the FSM file focused on control and can be unit-tested alone.

Test Plan:
- Basic divide: dataA=100, dataB=7, DIVU for 1 cycle -> busy high 32 cycles, then done=1, dataOut=64'h00000002_0000000E.
- Wide operands: dataA=32'hFFFFFFFF, dataB=1 -> dataOut=64'h00000000_FFFFFFFF. dataA=32'h80000000, dataB=32'h80000001 -> dataOut=64'h80000000_00000000.
- Divide by zero: dataA=5, dataB=0 -> done=1 one cycle after start, busy never high, dataOut=64'h00000005_FFFFFFFF.
- Stability: during RUN, change dataA/dataB and pulse DIVU and OUT -> ignored; result still that of the original operands at edge k+32.
- Reset mid-run: assert reset at iteration 10 -> next cycle busy=0, done=0, dataOut=0. A new DIVU 1000/10 then yields 64'h00000000_00000064.
- Back-to-back: in DONE, OUT then DIVU 9/4 -> done drops, then after 32 cycles dataOut=64'h00000001_00000002. DIVU issued directly in DONE behaves identically.
